load_store_unit: RTL and testbench
==================================

# load_store_unit

Memory-access stage directly downstream of the ALU: takes the ALU result as the effective address, together with funct3 and store data from the execute stage, and performs one load or store per request on a variable-latency, word-wide data-memory port. It generates byte enables and lane-replicated store data, extracts and sign/zero-extends load data, and flags misaligned or illegal accesses without touching memory. Little-endian, RV32I load/store semantics.

## Interface
- ADDR_WIDTH, 32, byte-address width; data path fixed at 32 bits.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- start_valid  in  1  request present.
- start_ready  out  1  unit can accept; high exactly in IDLE.
- is_store  in  1  1 = store, 0 = load.
- funct3  in  3  RV32I width/sign code.
- addr  in  ADDR_WIDTH  effective byte address (ALU output).
- store_data  in  32  register value to store.
- mem_req  out  1  memory request, held until acknowledged.
- mem_we  out  1  write enable for the request.
- mem_addr  out  ADDR_WIDTH  word-aligned address (addr[1:0] forced to 0).
- mem_be  out  4  byte enables, bit i = byte lane i (bits 8i+7:8i).
- mem_wdata  out  32  lane-replicated store data.
- mem_rdata  in  32  read data, valid when mem_ack is high.
- mem_ack  in  1  completes current request; may arrive in the first cycle mem_req is high.
- done  out  1  one-cycle completion pulse.
- fault  out  1  high with done when the access was misaligned or illegal.
- load_data  out  32  extended load result; valid from done, held until next done.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: start_ready=1. On start_valid, latch is_store, funct3, addr[1:0], store_data; decode:
  - legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; legal stores: 000 SB, 001 SH, 010 SW; all others illegal.
  - misaligned: half with addr[0]=1; word with addr[1:0]≠0.
  - illegal or misaligned → DONE with fault=1, no memory request, load_data unchanged.
  - otherwise → BUSY; register mem_addr={addr[ADDR_WIDTH-1:2],2'b00}, mem_we=is_store, mem_be, mem_wdata, mem_req=1.
- Byte enables: byte 4'b0001<<addr[1:0]; half 4'b0011<<{addr[1],1'b0}; word 4'b1111. Same for loads.
- Store data: byte {4{sd[7:0]}}; half {2{sd[15:0]}}; word sd.
- BUSY: hold mem_req and all mem_* outputs stable until mem_ack=1. On ack: mem_req=0, mem_be=0, mem_we=0; for loads, shift mem_rdata right by 8·addr[1:0], take byte/half/word, sign-extend (000, 001) or zero-extend (100, 101), register into load_data; → DONE.
- DONE: done=1 (fault as decided) for exactly one cycle → IDLE. Stores leave load_data unchanged.
- mem_ack outside BUSY is ignored. start_valid outside IDLE is ignored (not queued).

## Timing
- Reset values: state IDLE, start_ready=1, mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0, done=0, fault=0, load_data=0.
- Accept at edge N → mem_req high cycle N+1; ack in cycle N+1+k → done high cycle N+2+k. Minimum latency 2 cycles, throughput one access per 3 cycles.
- Faulting access: accept at N → done=fault=1 in cycle N+1; mem_req never asserts.
- start_ready deasserts the cycle after acceptance, returns in the cycle after done.
- rst in BUSY: next cycle mem_req=0 and all outputs at reset values; in-flight request abandoned, its later ack ignored.

## Test plan
- LB at 0x0000_0103, mem_rdata=0x80FF_1234, ack in first cycle → mem_be=1000, mem_addr=0x100, done at N+2, load_data=0xFFFF_FF80; repeat LBU → 0x0000_0080.
- SH at 0x0000_0202, store_data=0xDEAD_BEEF → mem_addr=0x200, mem_we=1, mem_be=1100, mem_wdata=0xBEEF_BEEF; load_data unchanged, fault=0.
- LW at 0x0000_0006, and load funct3=011 at 0x0 → done=fault=1 at N+1, mem_req stays 0, load_data unchanged.
- LHU at 0x0000_0002, ack delayed 3 cycles, mem_rdata=0x8001_0000 → mem_req/mem_addr/mem_be stable for 3 cycles, start_valid during BUSY ignored (start_ready=0), load_data=0x0000_8001 at done.
- Back-to-back SW 0x10 then LW 0x10 with zero-wait memory returning stored 0x1234_5678 → accepts 3 cycles apart, second done load_data=0x1234_5678.
- rst asserted in second BUSY cycle, ack arrives afterwards → outputs at reset values next cycle, no done pulse, start_ready=1.

Source files
------------

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Memory-access stage that follows the ALU. The ALU result is the effective
// byte address. Each accepted request does one RV32I load or store on a
// word-wide data-memory port whose latency can vary. The unit builds byte
// enables and lane-replicated store data, and it sign- or zero-extends load
// data. Misaligned or illegal accesses raise a fault and never touch memory.
// Byte order is little-endian.
//
// Handshakes:
//   - A request transfers on a rising edge where start_valid && start_ready.
//     start_ready is high only in IDLE. A start_valid seen outside IDLE is
//     dropped, not queued.
//   - The memory transfer completes on a rising edge where mem_req && mem_ack.
//     Every mem_* output holds steady from the moment mem_req rises until that
//     edge. mem_ack can arrive in the first cycle of mem_req. An ack that comes
//     while mem_req is low is ignored.
//   - done pulses for one cycle per accepted request. fault qualifies done.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   start_valid/_ready, is_store, funct3, addr, store_data   request side
//   mem_req, mem_we, mem_addr, mem_be, mem_wdata             memory request
//   mem_rdata, mem_ack                                       memory response
//   done, fault, load_data                                   completion
//   state_dbg       current FSM state (0 IDLE, 1 BUSY, 2 DONE)
// -----------------------------------------------------------------------------
module load_store_unit #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_valid,
  output logic                  start_ready,
  input  logic                  is_store,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           store_data,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_ack,
  output logic                  done,
  output logic                  fault,
  output logic [31:0]           load_data,
  output logic [1:0]            state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  is_store_q, is_store_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [1:0]            off_q, off_d;
  logic                  fault_q, fault_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]            mem_be_q, mem_be_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic [31:0]           load_data_q, load_data_d;

  // Decode of the request currently on the inputs.
  logic        req_legal;
  logic        req_misaligned;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;

  always_comb begin
    req_legal      = 1'b0;
    req_misaligned = 1'b0;
    req_be         = 4'b0000;
    req_wdata      = store_data;

    if (is_store) begin
      req_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
    end else begin
      req_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                  (funct3 == 3'b100) || (funct3 == 3'b101);
    end

    // funct3[1:0] gives the access size for every legal code.
    case (funct3[1:0])
      2'b00: begin
        req_be    = 4'b0001 << addr[1:0];
        req_wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        req_misaligned = addr[0];
        req_be         = 4'b0011 << {addr[1], 1'b0};
        req_wdata      = {2{store_data[15:0]}};
      end
      default: begin
        req_misaligned = (addr[1:0] != 2'b00);
        req_be         = 4'b1111;
        req_wdata      = store_data;
      end
    endcase
  end

  // Load extraction. The addressed byte or half is moved down to bit 0
  // first, so each width needs just one extension rule.
  logic [31:0] rdata_shifted;
  logic [31:0] load_ext;

  always_comb begin
    rdata_shifted = mem_rdata >> {off_q, 3'b000};
    load_ext      = rdata_shifted;
    case (funct3_q)
      3'b000:  load_ext = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
      3'b001:  load_ext = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
      3'b100:  load_ext = {24'h000000, rdata_shifted[7:0]};
      3'b101:  load_ext = {16'h0000, rdata_shifted[15:0]};
      default: load_ext = rdata_shifted;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    is_store_d  = is_store_q;
    funct3_d    = funct3_q;
    off_d       = off_q;
    fault_d     = fault_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    load_data_d = load_data_q;

    case (state_q)
      ST_IDLE: begin
        if (start_valid) begin
          is_store_d = is_store;
          funct3_d   = funct3;
          off_d      = addr[1:0];
          if (!req_legal || req_misaligned) begin
            // Fault path: go straight to DONE with no memory traffic.
            fault_d = 1'b1;
            state_d = ST_DONE;
          end else begin
            fault_d     = 1'b0;
            mem_req_d   = 1'b1;
            mem_we_d    = is_store;
            mem_addr_d  = {addr[ADDR_WIDTH-1:2], 2'b00};
            mem_be_d    = req_be;
            mem_wdata_d = req_wdata;
            state_d     = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          mem_be_d  = 4'b0000;
          if (!is_store_q) begin
            load_data_d = load_ext;
          end
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      is_store_q  <= 1'b0;
      funct3_q    <= 3'b000;
      off_q       <= 2'b00;
      fault_q     <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= 4'b0000;
      mem_wdata_q <= 32'h0;
      load_data_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      is_store_q  <= is_store_d;
      funct3_q    <= funct3_d;
      off_q       <= off_d;
      fault_q     <= fault_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      load_data_q <= load_data_d;
    end
  end

  assign start_ready = (state_q == ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign fault       = (state_q == ST_DONE) && fault_q;
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_be      = mem_be_q;
  assign mem_wdata   = mem_wdata_q;
  assign load_data   = load_data_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
//
// Directed bench for load_store_unit. Inputs change 1 ns after the rising
// edge, and outputs are sampled at that same point. The memory side runs in
// one of two modes:
//   - manual: man_ack and man_rdata are driven directly from the stimulus.
//   - auto:   a zero-wait responder acks every request as soon as it rises
//             and backs onto a small byte-lane-masked word array.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

  // Clock and reset.
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DUT connections.
  logic        start_valid = 1'b0;
  logic        start_ready;
  logic        is_store = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] store_data = 32'h0;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        done;
  logic        fault;
  logic [31:0] load_data;
  logic [1:0]  state_dbg;

  // Memory side.
  logic        auto_mem  = 1'b0;
  logic        man_ack   = 1'b0;
  logic [31:0] man_rdata = 32'h0;
  logic [31:0] mem_model [16];

  assign mem_ack   = auto_mem ? mem_req : man_ack;
  assign mem_rdata = auto_mem ? mem_model[mem_addr[5:2]] : man_rdata;

  always @(posedge clk) begin
    if (auto_mem && mem_req && mem_ack && mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be[b]) mem_model[mem_addr[5:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  load_store_unit #(.ADDR_WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .is_store    (is_store),
    .funct3      (funct3),
    .addr        (addr),
    .store_data  (store_data),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_be      (mem_be),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack),
    .done        (done),
    .fault       (fault),
    .load_data   (load_data),
    .state_dbg   (state_dbg)
  );

  // Scoreboard counters and cycle bookkeeping.
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int acc_prev = -1;
  int acc_last = -1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one cycle. The acceptance cycle is recorded from inputs that
  // are stable before the edge.
  task automatic tick();
    if (start_valid && start_ready) begin
      acc_prev = acc_last;
      acc_last = cyc;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Present one request for a single edge, then drop start_valid.
  task automatic issue(input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd);
    is_store    = st;
    funct3      = f3;
    addr        = a;
    store_data  = sd;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
  endtask

  // Ack in the current cycle with the given read data.
  task automatic ack_now(input logic [31:0] rd);
    man_rdata = rd;
    man_ack   = 1'b1;
    tick();
    man_ack   = 1'b0;
  endtask

  // Tick until done is seen, up to a cycle budget.
  task automatic wait_done(input string tag, input int limit);
    for (int i = 0; i < limit; i++) begin
      if (done) break;
      tick();
    end
    check_val(tag, {31'h0, done}, 32'h1);
  endtask

  // The cycle after done: back in IDLE and quiet.
  task automatic check_back_idle(input string tag);
    tick();
    check_val({tag, "_done_clr"}, {31'h0, done}, 32'h0);
    check_val({tag, "_ready"}, {31'h0, start_ready}, 32'h1);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem_model[i] = 32'h0;

    // Reset.
    tick();
    tick();
    rst = 1'b0;
    check_val("rst_ready", {31'h0, start_ready}, 32'h1);
    check_val("rst_req",   {31'h0, mem_req}, 32'h0);
    check_val("rst_we",    {31'h0, mem_we}, 32'h0);
    check_val("rst_addr",  mem_addr, 32'h0);
    check_val("rst_be",    {28'h0, mem_be}, 32'h0);
    check_val("rst_wdata", mem_wdata, 32'h0);
    check_val("rst_done",  {31'h0, done}, 32'h0);
    check_val("rst_fault", {31'h0, fault}, 32'h0);
    check_val("rst_ld",    load_data, 32'h0);

    // LB at 0x103, ack in the first cycle.
    issue(1'b0, 3'b000, 32'h0000_0103, 32'h0);
    check_val("lb_req",   {31'h0, mem_req}, 32'h1);
    check_val("lb_addr",  mem_addr, 32'h0000_0100);
    check_val("lb_be",    {28'h0, mem_be}, 32'h8);
    check_val("lb_we",    {31'h0, mem_we}, 32'h0);
    check_val("lb_ready", {31'h0, start_ready}, 32'h0);
    check_val("lb_nodone", {31'h0, done}, 32'h0);
    ack_now(32'h80FF_1234);
    check_val("lb_done",  {31'h0, done}, 32'h1);
    check_val("lb_fault", {31'h0, fault}, 32'h0);
    check_val("lb_ld",    load_data, 32'hFFFF_FF80);
    check_val("lb_req_clr", {31'h0, mem_req}, 32'h0);
    check_val("lb_be_clr",  {28'h0, mem_be}, 32'h0);
    check_back_idle("lb");

    // LBU at the same address.
    issue(1'b0, 3'b100, 32'h0000_0103, 32'h0);
    ack_now(32'h80FF_1234);
    check_val("lbu_done", {31'h0, done}, 32'h1);
    check_val("lbu_ld",   load_data, 32'h0000_0080);
    check_back_idle("lbu");

    // SH at 0x202.
    issue(1'b1, 3'b001, 32'h0000_0202, 32'hDEAD_BEEF);
    check_val("sh_addr",  mem_addr, 32'h0000_0200);
    check_val("sh_we",    {31'h0, mem_we}, 32'h1);
    check_val("sh_be",    {28'h0, mem_be}, 32'hC);
    check_val("sh_wdata", mem_wdata, 32'hBEEF_BEEF);
    ack_now(32'h0);
    check_val("sh_done",  {31'h0, done}, 32'h1);
    check_val("sh_fault", {31'h0, fault}, 32'h0);
    check_val("sh_ld",    load_data, 32'h0000_0080);
    check_val("sh_we_clr", {31'h0, mem_we}, 32'h0);
    check_back_idle("sh");

    // SB at 0x1: a single lane, with the byte replicated.
    issue(1'b1, 3'b000, 32'h0000_0001, 32'h1122_33A5);
    check_val("sb_be",    {28'h0, mem_be}, 32'h2);
    check_val("sb_wdata", mem_wdata, 32'hA5A5_A5A5);
    ack_now(32'h0);
    check_val("sb_done",  {31'h0, done}, 32'h1);
    check_back_idle("sb");

    // Misaligned LW at 0x6.
    issue(1'b0, 3'b010, 32'h0000_0006, 32'h0);
    check_val("lwmis_done",  {31'h0, done}, 32'h1);
    check_val("lwmis_fault", {31'h0, fault}, 32'h1);
    check_val("lwmis_req",   {31'h0, mem_req}, 32'h0);
    check_val("lwmis_ld",    load_data, 32'h0000_0080);
    check_back_idle("lwmis");

    // Illegal load funct3 011 at 0x0.
    issue(1'b0, 3'b011, 32'h0000_0000, 32'h0);
    check_val("ill_done",  {31'h0, done}, 32'h1);
    check_val("ill_fault", {31'h0, fault}, 32'h1);
    check_val("ill_req",   {31'h0, mem_req}, 32'h0);
    check_val("ill_ld",    load_data, 32'h0000_0080);
    check_back_idle("ill");
    check_val("ill_fault_clr", {31'h0, fault}, 32'h0);

    // Illegal store funct3 100.
    issue(1'b1, 3'b100, 32'h0000_0000, 32'h0);
    check_val("sill_fault", {31'h0, fault}, 32'h1);
    check_val("sill_req",   {31'h0, mem_req}, 32'h0);
    check_back_idle("sill");

    // LHU at 0x2, ack held off for 3 cycles, while a stray request is
    // presented during BUSY.
    issue(1'b0, 3'b101, 32'h0000_0002, 32'h0);
    is_store    = 1'b1;
    funct3      = 3'b010;
    addr        = 32'h0000_0040;
    start_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check_val("lhu_req",   {31'h0, mem_req}, 32'h1);
      check_val("lhu_addr",  mem_addr, 32'h0000_0000);
      check_val("lhu_be",    {28'h0, mem_be}, 32'hC);
      check_val("lhu_we",    {31'h0, mem_we}, 32'h0);
      check_val("lhu_ready", {31'h0, start_ready}, 32'h0);
      tick();
    end
    start_valid = 1'b0;
    ack_now(32'h8001_0000);
    check_val("lhu_done", {31'h0, done}, 32'h1);
    check_val("lhu_ld",   load_data, 32'h0000_8001);
    check_back_idle("lhu");
    check_val("lhu_noqueue", {31'h0, mem_req}, 32'h0);

    // Back-to-back SW then LW through the zero-wait memory.
    auto_mem = 1'b1;
    issue(1'b1, 3'b010, 32'h0000_0010, 32'h1234_5678);
    is_store    = 1'b0;
    funct3      = 3'b010;
    addr        = 32'h0000_0010;
    start_valid = 1'b1;
    wait_done("sw_done", 10);
    tick();
    check_val("b2b_ready", {31'h0, start_ready}, 32'h1);
    tick();
    start_valid = 1'b0;
    check_val("b2b_gap", acc_last - acc_prev, 32'd3);
    wait_done("lw_done", 10);
    check_val("lw_ld", load_data, 32'h1234_5678);
    check_back_idle("lw");
    auto_mem = 1'b0;

    // Reset in the second BUSY cycle; the late ack must be ignored.
    issue(1'b0, 3'b010, 32'h0000_0020, 32'h0);
    tick();
    check_val("rb_busy", {31'h0, mem_req}, 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("rb_req",   {31'h0, mem_req}, 32'h0);
    check_val("rb_addr",  mem_addr, 32'h0);
    check_val("rb_be",    {28'h0, mem_be}, 32'h0);
    check_val("rb_wdata", mem_wdata, 32'h0);
    check_val("rb_done",  {31'h0, done}, 32'h0);
    check_val("rb_ready", {31'h0, start_ready}, 32'h1);
    check_val("rb_ld",    load_data, 32'h0);
    ack_now(32'hCAFE_F00D);
    check_val("rb_late_done",  {31'h0, done}, 32'h0);
    check_val("rb_late_ready", {31'h0, start_ready}, 32'h1);
    check_val("rb_late_ld",    load_data, 32'h0);
    tick();
    check_val("rb_late_done2", {31'h0, done}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
